// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: multi-cycle phase FSM (F,D,E,M,WB) with step/run modes, ecall halt and retire count
//  in : clk, rst (sync, active-high), run_mode, step_btn (raw), ecall, mem_access
//  out: fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, phase[2:0], halted, retired[CNT_WIDTH-1:0]
module cpu_phase_sequencer #(
  parameter int MEM_WAIT  = 1,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_mode,
  input  logic                 step_btn,
  input  logic                 ecall,
  input  logic                 mem_access,
  output logic                 fetch_en,
  output logic                 decode_en,
  output logic                 exec_en,
  output logic                 mem_en,
  output logic                 wb_en,
  output logic                 pc_en,
  output logic [2:0]           phase,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] retired
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;
  state_t     state;
  logic [3:0] wcnt;
  logic       mem_flag;
  logic       s1, s2, s3;
  logic       step_pulse;
  assign step_pulse = s2 & ~s3;
  assign phase      = state;
  assign fetch_en   = state == FETCH;
  assign decode_en  = state == DECODE;
  assign exec_en    = state == EXEC;
  assign mem_en     = state == MEM;
  assign wb_en      = state == WB;
  assign halted     = state == HALT;
  // the resume pulse out of HALT also advances the PC past the ecall
  assign pc_en      = wb_en | (halted & step_pulse);
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      mem_flag <= 1'b0;
      {s1, s2, s3} <= 3'b000;
      retired  <= '0;
    end else begin
      {s1, s2, s3} <= {step_btn, s1, s2};
      if (pc_en) retired <= retired + 1'b1;
      case (state)
        IDLE:    if (run_mode || step_pulse) state <= FETCH;
        FETCH:   state <= DECODE;
        DECODE: begin
          mem_flag <= mem_access;
          state    <= ecall ? HALT : EXEC;
        end
        EXEC:    state <= mem_flag ? MEM : WB;
        MEM: begin
          if (wcnt < 4'(MEM_WAIT)) wcnt <= wcnt + 1'b1;
          else begin
            wcnt  <= '0;
            state <= WB;
          end
        end
        WB:      state <= run_mode ? FETCH : IDLE;
        HALT:    if (step_pulse) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed checks of phase sequencing, mem waits, halt/resume, stepping, reset and counter wrap
module tb_cpu_phase_sequencer;
  logic clk = 1'b0, rst = 1'b1, run_mode = 1'b0, step_btn = 1'b0, ecall = 1'b0, mem_access = 1'b0;
  logic a_f, a_d, a_e, a_m, a_w, a_pc, a_h;
  logic b_f, b_d, b_e, b_m, b_w, b_pc, b_h;
  logic [2:0] a_phase, b_phase;
  logic [31:0] a_ret;
  logic [3:0] b_ret;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  cpu_phase_sequencer #(.MEM_WAIT(2), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn), .ecall(ecall), .mem_access(mem_access),
    .fetch_en(a_f), .decode_en(a_d), .exec_en(a_e), .mem_en(a_m), .wb_en(a_w), .pc_en(a_pc),
    .phase(a_phase), .halted(a_h), .retired(a_ret)
  );
  cpu_phase_sequencer #(.MEM_WAIT(3), .CNT_WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn), .ecall(ecall), .mem_access(mem_access),
    .fetch_en(b_f), .decode_en(b_d), .exec_en(b_e), .mem_en(b_m), .wb_en(b_w), .pc_en(b_pc),
    .phase(b_phase), .halted(b_h), .retired(b_ret)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [5:0] en_of(logic [2:0] p);
    return {p == 3'd6, p == 3'd5, p == 3'd4, p == 3'd3, p == 3'd2, p == 3'd1};
  endfunction
  task automatic chk_a(string tag, logic [2:0] exp);
    chk({tag, " phase"}, 32'(a_phase), 32'(exp));
    chk({tag, " en"}, 32'({a_h, a_w, a_m, a_e, a_d, a_f}), 32'(en_of(exp)));
    if (exp != 3'd6) chk({tag, " pc_en"}, 32'(a_pc), 32'(exp == 3'd5));
  endtask
  task automatic chk_b(string tag, logic [2:0] exp);
    chk({tag, " phase"}, 32'(b_phase), 32'(exp));
    chk({tag, " en"}, 32'({b_h, b_w, b_m, b_e, b_d, b_f}), 32'(en_of(exp)));
    if (exp != 3'd6) chk({tag, " pc_en"}, 32'(b_pc), 32'(exp == 3'd5));
  endtask
  logic [2:0] seq1 [8]  = '{1, 2, 3, 5, 1, 2, 3, 5};
  logic [2:0] held [10] = '{0, 0, 1, 2, 3, 5, 0, 0, 0, 0};
  logic       tbtn [9]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0};
  logic [2:0] tph  [9]  = '{0, 0, 1, 2, 3, 5, 0, 0, 0};
  initial begin
    run_mode = 1'b1;
    tick;
    tick;
    chk_a("reset", 3'd0);
    chk("reset retired", a_ret, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_a("run seq", seq1[i]);
    end
    tick;
    chk_a("run next", 3'd1);
    chk("run retired", a_ret, 2);
    mem_access = 1'b1;
    tick;
    chk_a("mem dec", 3'd2);
    tick;
    chk_a("mem exec", 3'd3);
    mem_access = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_a("mem wait", 3'd4);
    end
    tick;
    chk_a("mem wb", 3'd5);
    tick;
    chk_a("mem next", 3'd1);
    chk("mem retired", a_ret, 3);
    ecall = 1'b1;
    mem_access = 1'b1;
    tick;
    chk_a("ecall dec", 3'd2);
    tick;
    ecall = 1'b0;
    mem_access = 1'b0;
    chk_a("halt enter", 3'd6);
    for (int i = 0; i < 20; i++) begin
      tick;
      chk_a("halt hold", 3'd6);
      chk("halt pc_en", 32'(a_pc), 0);
    end
    chk("halt retired", a_ret, 3);
    step_btn = 1'b1;
    tick;
    chk("resume sync", 32'(a_pc), 0);
    tick;
    chk("resume pc_en", 32'(a_pc), 1);
    chk_a("resume halt", 3'd6);
    tick;
    chk_a("resume idle", 3'd0);
    chk("resume retired", a_ret, 4);
    tick;
    chk_a("resume fetch", 3'd1);
    step_btn = 1'b0;
    run_mode = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick;
      chk_a("step drain", i < 3 ? (i == 2 ? 3'd5 : 3'(i + 2)) : 3'd0);
    end
    chk("drain retired", a_ret, 5);
    step_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk_a("step held", held[i]);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_a("step rel", 3'd0);
    end
    chk("held retired", a_ret, 6);
    for (int i = 0; i < 9; i++) begin
      step_btn = tbtn[i];
      tick;
      chk_a("step twice", tph[i]);
    end
    chk("twice retired", a_ret, 7);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    run_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_b("w4 pre", i == 3 ? 3'd5 : 3'(i + 1));
    end
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_b("w4 in", 3'(i + 1));
    end
    mem_access = 1'b0;
    tick;
    chk_b("w4 mem", 3'd4);
    tick;
    chk_b("w4 mem", 3'd4);
    chk("w4 pre retired", 32'(b_ret), 1);
    rst = 1'b1;
    tick;
    chk_b("mid-mem rst", 3'd0);
    chk("mid-mem retired", 32'(b_ret), 0);
    tick;
    chk_b("mid-mem rst2", 3'd0);
    rst = 1'b0;
    tick;
    chk_b("wrap fetch", 3'd1);
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk_b("wrap dec", 3'd2);
      tick;
      chk_b("wrap exec", 3'd3);
      tick;
      chk_b("wrap wb", 3'd5);
      tick;
      chk_b("wrap next", 3'd1);
      chk("wrap retired", 32'(b_ret), 32'(k % 16));
    end
    tick;
    chk_b("stop dec", 3'd2);
    tick;
    chk_b("stop exec", 3'd3);
    run_mode = 1'b0;
    tick;
    chk_b("stop wb", 3'd5);
    tick;
    chk_b("stop idle", 3'd0);
    tick;
    chk_b("stop idle2", 3'd0);
    chk("stop retired", 32'(b_ret), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
